// File: rtl/fazyrv_pkg.sv
// Shared types and constants for the FazyRV memory arbiter.
//   arb_state_e : arbiter FSM states
//   CON_DONE    : console history pattern that flags a passing run ("DONE")
//   CON_ERR     : console history tail that flags a failing run ("ERR")
package fazyrv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IMEM = 2'd1,
    DMEM = 2'd2,
    CON  = 2'd3
  } arb_state_e;

  localparam logic [31:0] CON_DONE = 32'h444F_4E45;
  localparam logic [23:0] CON_ERR  = 24'h45_5252;

endpackage

// File: rtl/fazyrv_con_sink.sv
// Console sink: registers each console byte as a one-cycle pulse, keeps a
// four-byte history and raises sticky pass/fail flags when the history
// spells "DONE" or ends in "ERR".
//   clk_i, rst_in : clock, async active-low reset
//   wr_i          : console write strobe (one cycle per byte)
//   wr_dat_i      : byte being written
//   con_valid_o   : one-cycle pulse after each write
//   con_char_o    : the byte of the latest write
//   done_o, err_o : sticky pass / fail flags
module fazyrv_con_sink
  import fazyrv_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic       wr_i,
  input  logic [7:0] wr_dat_i,
  output logic       con_valid_o,
  output logic [7:0] con_char_o,
  output logic       done_o,
  output logic       err_o
);

  logic [31:0] hist_q;
  logic [31:0] hist_nxt;

  assign hist_nxt = {hist_q[23:0], wr_dat_i};

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      hist_q      <= '0;
      con_valid_o <= 1'b0;
      con_char_o  <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      con_valid_o <= wr_i;
      if (wr_i) begin
        con_char_o <= wr_dat_i;
        hist_q     <= hist_nxt;
        // Flags test the history including the byte just written.
        if (hist_nxt == CON_DONE)      done_o <= 1'b1;
        if (hist_nxt[23:0] == CON_ERR) err_o  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fazyrv_mem_arb.sv
// Arbitrates a fetch port (imem) and a data port (dmem) onto one Wishbone
// memory port, and diverts data accesses with adr[SCRATCH_BIT] set to a
// console sink instead of memory.
//   clk_i, rst_in : clock, async active-low reset
//   imem_*        : fetch master (read only)
//   dmem_*        : data master
//   mem_*         : shared memory slave, word addressed
//   con_*, done_o, err_o : console output and sticky pass/fail flags
//
// state | meaning
// IDLE  | no grant; arbitrate pending requests
// IMEM  | fetch port owns the memory bus
// DMEM  | data port owns the memory bus
// CON   | data port talks to the console; ack this cycle
module fazyrv_mem_arb
  import fazyrv_pkg::*;
#(
  parameter int SCRATCH_BIT = 28,
  parameter int MEM_AW      = 15
) (
  input  logic              clk_i,
  input  logic              rst_in,

  input  logic              imem_cyc_i,
  input  logic              imem_stb_i,
  input  logic [31:0]       imem_adr_i,
  output logic [31:0]       imem_dat_o,
  output logic              imem_ack_o,

  input  logic              dmem_cyc_i,
  input  logic              dmem_stb_i,
  input  logic              dmem_we_i,
  input  logic [3:0]        dmem_be_i,
  input  logic [31:0]       dmem_adr_i,
  input  logic [31:0]       dmem_dat_i,
  output logic [31:0]       dmem_dat_o,
  output logic              dmem_ack_o,

  output logic              mem_cyc_o,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_adr_o,
  output logic [31:0]       mem_dat_o,
  input  logic [31:0]       mem_dat_i,
  input  logic              mem_ack_i,

  output logic              con_valid_o,
  output logic [7:0]        con_char_o,
  output logic              done_o,
  output logic              err_o
);

  arb_state_e state_q, state_d;
  logic       last_dmem_q;
  logic       ireq, dreq, pick_dmem;
  logic       con_wr;
  logic       unused_adr;

  assign ireq = imem_cyc_i & imem_stb_i;
  assign dreq = dmem_cyc_i & dmem_stb_i;

  // Only the word-address slice and the console bit are decoded.
  assign unused_adr = ^{imem_adr_i, dmem_adr_i};

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      last_dmem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d != IDLE) last_dmem_q <= (state_d != IMEM);
    end
  end

  always_comb begin
    state_d    = state_q;
    pick_dmem  = 1'b0;
    mem_cyc_o  = 1'b0;
    mem_stb_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = '0;
    mem_adr_o  = '0;
    mem_dat_o  = '0;
    imem_ack_o = 1'b0;
    dmem_ack_o = 1'b0;
    imem_dat_o = mem_dat_i;
    dmem_dat_o = mem_dat_i;
    con_wr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time gets the bus.
        pick_dmem = (ireq && dreq) ? !last_dmem_q : dreq;
        if (ireq || dreq) begin
          if (pick_dmem) state_d = dmem_adr_i[SCRATCH_BIT] ? CON : DMEM;
          else           state_d = IMEM;
        end
      end
      IMEM: begin
        mem_cyc_o  = imem_cyc_i;
        mem_stb_o  = imem_stb_i;
        mem_be_o   = 4'hF;
        mem_adr_o  = imem_adr_i[MEM_AW+1:2];
        imem_ack_o = imem_cyc_i & mem_ack_i;
        // A dropped cycle aborts without re-arbitrating this cycle.
        if (!imem_cyc_i || mem_ack_i) state_d = IDLE;
      end
      DMEM: begin
        mem_cyc_o  = dmem_cyc_i;
        mem_stb_o  = dmem_stb_i;
        mem_we_o   = dmem_we_i;
        mem_be_o   = dmem_be_i;
        mem_adr_o  = dmem_adr_i[MEM_AW+1:2];
        mem_dat_o  = dmem_dat_i;
        dmem_ack_o = dmem_cyc_i & mem_ack_i;
        if (!dmem_cyc_i || mem_ack_i) state_d = IDLE;
      end
      CON: begin
        dmem_dat_o = '0;
        dmem_ack_o = dmem_cyc_i;
        con_wr     = dmem_cyc_i & dmem_we_i;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  fazyrv_con_sink u_con_sink (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .wr_i        (con_wr),
    .wr_dat_i    (dmem_dat_i[7:0]),
    .con_valid_o (con_valid_o),
    .con_char_o  (con_char_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

endmodule

// File: tb/tb_fazyrv_mem_arb.sv
module tb_fazyrv_mem_arb;

  localparam int MEM_AW = 15;

  logic              clk_i;
  logic              rst_in;
  logic              imem_cyc_i, imem_stb_i;
  logic [31:0]       imem_adr_i, imem_dat_o;
  logic              imem_ack_o;
  logic              dmem_cyc_i, dmem_stb_i, dmem_we_i;
  logic [3:0]        dmem_be_i;
  logic [31:0]       dmem_adr_i, dmem_dat_i, dmem_dat_o;
  logic              dmem_ack_o;
  logic              mem_cyc_o, mem_stb_o, mem_we_o;
  logic [3:0]        mem_be_o;
  logic [MEM_AW-1:0] mem_adr_o;
  logic [31:0]       mem_dat_o, mem_dat_i;
  logic              mem_ack_i;
  logic              con_valid_o;
  logic [7:0]        con_char_o;
  logic              done_o, err_o;

  fazyrv_mem_arb #(.SCRATCH_BIT(28), .MEM_AW(MEM_AW)) dut (
    .clk_i(clk_i), .rst_in(rst_in),
    .imem_cyc_i(imem_cyc_i), .imem_stb_i(imem_stb_i), .imem_adr_i(imem_adr_i),
    .imem_dat_o(imem_dat_o), .imem_ack_o(imem_ack_o),
    .dmem_cyc_i(dmem_cyc_i), .dmem_stb_i(dmem_stb_i), .dmem_we_i(dmem_we_i),
    .dmem_be_i(dmem_be_i), .dmem_adr_i(dmem_adr_i), .dmem_dat_i(dmem_dat_i),
    .dmem_dat_o(dmem_dat_o), .dmem_ack_o(dmem_ack_o),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i),
    .con_valid_o(con_valid_o), .con_char_o(con_char_o),
    .done_o(done_o), .err_o(err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int errors = 0;
  int checks = 0;

  // Event counters sampled on the falling edge while out of reset.
  int n_iack = 0, n_dack = 0, n_cval = 0, n_stb = 0;
  always @(negedge clk_i) begin
    if (rst_in === 1'b1) begin
      n_iack = n_iack + int'(imem_ack_o);
      n_dack = n_dack + int'(dmem_ack_o);
      n_cval = n_cval + int'(con_valid_o);
      n_stb  = n_stb + int'(mem_stb_o);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_i(input logic cyc, input logic [31:0] adr);
    imem_cyc_i = cyc;
    imem_stb_i = cyc;
    imem_adr_i = adr;
  endtask

  task automatic set_d(input logic cyc, input logic we, input logic [3:0] be,
                       input logic [31:0] adr, input logic [31:0] dat);
    dmem_cyc_i = cyc;
    dmem_stb_i = cyc;
    dmem_we_i  = we;
    dmem_be_i  = be;
    dmem_adr_i = adr;
    dmem_dat_i = dat;
  endtask

  // One console byte write; starts and ends in an idle cycle slot.
  task automatic con_wr(input logic [7:0] ch);
    set_d(1'b1, 1'b1, 4'h1, 32'h1000_0000, {24'h0, ch});
    tick();
    @(negedge clk_i);
    chk("con_wr_ack", 32'({imem_ack_o, dmem_ack_o}), 32'b01);
    tick();
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    chk("con_valid_char", 32'({con_valid_o, con_char_o}), 32'({1'b1, ch}));
    tick();
  endtask

  typedef struct {
    logic              d;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       adr;
    logic [31:0]       wdat;
    int                lat;
    logic [31:0]       rdat;
    logic              exp_con;
    logic [MEM_AW-1:0] exp_adr;
    logic [3:0]        exp_be;
    logic [31:0]       exp_rd;
  } vec_t;

  vec_t vt[8];
  int ia0, da0, ca0, sb0;

  initial begin
    vt[0] = '{d:1'b0, we:1'b0, be:4'h0, adr:32'h0000_0100, wdat:32'h0, lat:2,
              rdat:32'hDEAD_BEEF, exp_con:1'b0, exp_adr:15'h0040, exp_be:4'hF, exp_rd:32'hDEAD_BEEF};
    vt[1] = '{d:1'b1, we:1'b0, be:4'hF, adr:32'h0000_0200, wdat:32'h0, lat:0,
              rdat:32'h1234_5678, exp_con:1'b0, exp_adr:15'h0080, exp_be:4'hF, exp_rd:32'h1234_5678};
    vt[2] = '{d:1'b1, we:1'b1, be:4'h3, adr:32'h0000_1234, wdat:32'hCAFE_F00D, lat:1,
              rdat:32'h0, exp_con:1'b0, exp_adr:15'h048D, exp_be:4'h3, exp_rd:32'h0};
    vt[3] = '{d:1'b0, we:1'b0, be:4'h0, adr:32'h0000_7FFC, wdat:32'h0, lat:0,
              rdat:32'h0BAD_F00D, exp_con:1'b0, exp_adr:15'h1FFF, exp_be:4'hF, exp_rd:32'h0BAD_F00D};
    vt[4] = '{d:1'b0, we:1'b0, be:4'h0, adr:32'h0001_FFFC, wdat:32'h0, lat:1,
              rdat:32'h55AA_55AA, exp_con:1'b0, exp_adr:15'h7FFF, exp_be:4'hF, exp_rd:32'h55AA_55AA};
    vt[5] = '{d:1'b0, we:1'b0, be:4'h0, adr:32'h0002_0004, wdat:32'h0, lat:0,
              rdat:32'h1357_9BDF, exp_con:1'b0, exp_adr:15'h0001, exp_be:4'hF, exp_rd:32'h1357_9BDF};
    vt[6] = '{d:1'b1, we:1'b0, be:4'hF, adr:32'h1000_0000, wdat:32'h0, lat:0,
              rdat:32'hA5A5_A5A5, exp_con:1'b1, exp_adr:15'h0, exp_be:4'h0, exp_rd:32'h0};
    vt[7] = '{d:1'b1, we:1'b1, be:4'h8, adr:32'h8000_0010, wdat:32'h0102_0304, lat:0,
              rdat:32'h0, exp_con:1'b0, exp_adr:15'h0004, exp_be:4'h8, exp_rd:32'h0};

    rst_in = 1'b1;
    set_i(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mem_ack_i = 1'b0;
    mem_dat_i = 32'h0;
    #2 rst_in = 1'b0;
    #1;
    chk("reset_ctrl", 32'({mem_cyc_o, mem_stb_o, mem_we_o, imem_ack_o, dmem_ack_o,
                           con_valid_o, done_o, err_o}), 32'h0);
    chk("reset_adr", 32'(mem_adr_o), 32'h0);
    tick();
    tick();
    rst_in = 1'b1;
    tick();

    // Single-master transactions.
    for (int i = 0; i < 8; i++) begin
      ia0 = n_iack; da0 = n_dack; ca0 = n_cval;
      if (vt[i].d) set_d(1'b1, vt[i].we, vt[i].be, vt[i].adr, vt[i].wdat);
      else         set_i(1'b1, vt[i].adr);
      if (vt[i].exp_con) mem_dat_i = vt[i].rdat;
      @(negedge clk_i);
      chk("req_cycle_no_stb", 32'(mem_stb_o), 32'h0);
      tick();
      if (vt[i].exp_con) begin
        @(negedge clk_i);
        chk("con_ack", 32'({imem_ack_o, dmem_ack_o}), 32'b01);
        chk("con_rdata", dmem_dat_o, vt[i].exp_rd);
        chk("con_no_stb", 32'(mem_stb_o), 32'h0);
      end else begin
        for (int k = 0; k < vt[i].lat; k++) begin
          @(negedge clk_i);
          chk("wait_stb_noack", 32'({mem_stb_o, imem_ack_o, dmem_ack_o}), 32'b100);
          tick();
        end
        mem_ack_i = 1'b1;
        mem_dat_i = vt[i].rdat;
        @(negedge clk_i);
        chk("ack_route", 32'({imem_ack_o, dmem_ack_o}), vt[i].d ? 32'b01 : 32'b10);
        chk("mem_adr", 32'(mem_adr_o), 32'(vt[i].exp_adr));
        chk("mem_we", 32'(mem_we_o), 32'(vt[i].d & vt[i].we));
        chk("mem_be", 32'(mem_be_o), 32'(vt[i].exp_be));
        chk("mem_wdat", mem_dat_o, vt[i].d ? vt[i].wdat : 32'h0);
        chk("rdata", vt[i].d ? dmem_dat_o : imem_dat_o, vt[i].exp_rd);
      end
      tick();
      set_i(1'b0, 32'h0);
      set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      mem_ack_i = 1'b0;
      mem_dat_i = 32'h0;
      tick();
      chk("iack_count", 32'(n_iack - ia0), vt[i].d ? 32'd0 : 32'd1);
      chk("dack_count", 32'(n_dack - da0), vt[i].d ? 32'd1 : 32'd0);
      chk("no_con_pulse", 32'(n_cval - ca0), 32'd0);
    end

    // Simultaneous requests, last grant was dmem: imem first, then dmem.
    set_i(1'b1, 32'h0);
    set_d(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    @(negedge clk_i);
    chk("pair1_req_no_stb", 32'(mem_stb_o), 32'h0);
    tick();
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("pair1_first_imem", 32'({imem_ack_o, dmem_ack_o}), 32'b10);
    chk("pair1_first_adr", 32'(mem_adr_o), 32'h0);
    tick();
    set_i(1'b0, 32'h0);
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("pair1_idle_gap", 32'({mem_stb_o, imem_ack_o, dmem_ack_o}), 32'b000);
    tick();
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("pair1_second_dmem", 32'({imem_ack_o, dmem_ack_o}), 32'b01);
    chk("pair1_second_adr", 32'(mem_adr_o), 32'h80);
    tick();
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mem_ack_i = 1'b0;
    set_i(1'b1, 32'h4);
    tick();
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("solo_fetch_ack", 32'({imem_ack_o, dmem_ack_o}), 32'b10);
    tick();
    mem_ack_i = 1'b0;
    // Last grant now imem: the second pair goes dmem first.
    set_i(1'b1, 32'h0);
    set_d(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    tick();
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("pair2_first_dmem", 32'({imem_ack_o, dmem_ack_o}), 32'b01);
    tick();
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mem_ack_i = 1'b0;
    tick();
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("pair2_second_imem", 32'({imem_ack_o, dmem_ack_o}), 32'b10);
    tick();
    set_i(1'b0, 32'h0);
    mem_ack_i = 1'b0;
    tick();

    // Console "DONE".
    ca0 = n_cval; sb0 = n_stb;
    chk("done_before", 32'(done_o), 32'h0);
    con_wr(8'h44);
    con_wr(8'h4F);
    con_wr(8'h4E);
    chk("done_after_3", 32'(done_o), 32'h0);
    con_wr(8'h45);
    chk("done_after_4", 32'({done_o, err_o}), 32'b10);
    chk("done_pulses", 32'(n_cval - ca0), 32'd4);
    chk("done_no_mem_stb", 32'(n_stb - sb0), 32'd0);
    con_wr(8'h78);
    chk("done_sticky", 32'(done_o), 32'h1);

    // Reset, then "xERR" and a console read.
    rst_in = 1'b0;
    #1;
    chk("rst_clears_done", 32'(done_o), 32'h0);
    tick();
    rst_in = 1'b1;
    tick();
    con_wr(8'h78);
    con_wr(8'h45);
    con_wr(8'h52);
    chk("err_after_3", 32'(err_o), 32'h0);
    con_wr(8'h52);
    chk("err_after_4", 32'({done_o, err_o}), 32'b01);
    mem_dat_i = 32'hFFFF_FFFF;
    set_d(1'b1, 1'b0, 4'hF, 32'h1000_0000, 32'h0);
    tick();
    @(negedge clk_i);
    chk("con_read_ack", 32'(dmem_ack_o), 32'h1);
    chk("con_read_zero", dmem_dat_o, 32'h0);
    tick();
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mem_dat_i = 32'h0;
    tick();

    // Abort: dmem drops cyc before ack while imem starts requesting.
    da0 = n_dack;
    set_d(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    tick();
    @(negedge clk_i);
    chk("abort_dmem_stb", 32'(mem_stb_o), 32'h1);
    tick();
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_i(1'b1, 32'h8);
    @(negedge clk_i);
    chk("abort_no_ack", 32'({imem_ack_o, dmem_ack_o, mem_cyc_o}), 32'b000);
    tick();
    @(negedge clk_i);
    chk("abort_idle_no_rearb", 32'(mem_stb_o), 32'h0);
    tick();
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("abort_next_fetch", 32'({imem_ack_o, mem_adr_o}), 32'({1'b1, 15'h0002}));
    tick();
    set_i(1'b0, 32'h0);
    mem_ack_i = 1'b0;
    chk("abort_dack_count", 32'(n_dack - da0), 32'd0);
    tick();

    // Reset in the middle of a DMEM access.
    set_d(1'b1, 1'b1, 4'hF, 32'h400, 32'h1111_2222);
    tick();
    @(negedge clk_i);
    chk("mid_dmem_stb", 32'({mem_stb_o, mem_we_o}), 32'b11);
    #2;
    rst_in = 1'b0;
    mem_ack_i = 1'b1;
    #1;
    chk("rst_now_ctrl", 32'({mem_cyc_o, mem_stb_o, mem_we_o, imem_ack_o, dmem_ack_o,
                             con_valid_o, done_o, err_o}), 32'h0);
    chk("rst_now_adr", 32'({mem_be_o, mem_adr_o}), 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk_i);
    #1;
    rst_in = 1'b1;
    ia0 = n_iack; da0 = n_dack;
    tick();
    tick();
    tick();
    mem_ack_i = 1'b0;
    chk("rst_no_stray_ack", 32'((n_iack - ia0) + (n_dack - da0)), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fazyrv_mem_arb.md
FAZYRV_MEM_ARB -- requirements
Module: fazyrv_mem_arb

Interface
REQ-001 SHALL have parameter SCRATCH_BIT, default 28, the address bit that selects the console region.
REQ-002 SHALL have parameter MEM_AW, default 15, the word-address width forwarded to memory.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have imem ports:
- imem_cyc_i, input, 1, fetch cycle valid.
- imem_stb_i, input, 1, fetch request strobe.
- imem_adr_i, input, 32, fetch byte address.
- imem_dat_o, output, 32, fetch read data.
- imem_ack_o, output, 1, fetch acknowledge.
REQ-006 SHALL have dmem ports:
- dmem_cyc_i, input, 1, data cycle valid.
- dmem_stb_i, input, 1, data request strobe.
- dmem_we_i, input, 1, write enable.
- dmem_be_i, input, 4, byte enables.
- dmem_adr_i, input, 32, data byte address.
- dmem_dat_i, input, 32, write data.
- dmem_dat_o, output, 32, read data.
- dmem_ack_o, output, 1, data acknowledge.
REQ-007 SHALL have mem ports:
- mem_cyc_o, output, 1, cycle valid to memory.
- mem_stb_o, output, 1, strobe to memory.
- mem_we_o, output, 1, write enable to memory.
- mem_be_o, output, 4, byte enables to memory.
- mem_adr_o, output, MEM_AW, word address = adr[MEM_AW+1:2].
- mem_dat_o, output, 32, write data to memory.
- mem_dat_i, input, 32, read data from memory.
- mem_ack_i, input, 1, memory acknowledge.
REQ-008 SHALL have console ports:
- con_valid_o, output, 1, one-cycle pulse per console write.
- con_char_o, output, 8, the written byte.
- done_o, output, 1, sticky pass flag.
- err_o, output, 1, sticky fail flag.

Function
REQ-009 SHALL implement FSM states IDLE, IMEM, DMEM and CON; after reset the FSM is in IDLE.
REQ-010 In IDLE, a request is a port's cyc&stb; a dmem request with adr[SCRATCH_BIT]=1 SHALL go to CON.
REQ-011 In IDLE, any other request SHALL go to IMEM or DMEM.
REQ-012 When both ports request in the same cycle, the port not granted last SHALL win; after reset the last-granted port is imem.
REQ-013 The mem_* outputs SHALL be driven from the granted master only while in IMEM or DMEM; mem_cyc_o, mem_stb_o and mem_we_o SHALL be 0 otherwise.
REQ-014 mem_ack_i SHALL be routed only to the granted master's ack_o, the same cycle (combinational).
REQ-015 mem_dat_i SHALL be routed to both imem_dat_o and dmem_dat_o.
REQ-016 On an acked cycle the FSM SHALL return to IDLE, so there is one idle cycle between grants.
REQ-017 If the granted master drops cyc before ack, the FSM SHALL return to IDLE with no ack and no re-arbitration in that cycle.
REQ-018 CON SHALL raise dmem_ack_o for exactly one cycle, the cycle after entry, then return to IDLE.
REQ-019 A console read SHALL return 0.
REQ-020 A console write SHALL pulse con_valid_o once, with con_char_o = dmem_dat_i[7:0], and shift that byte into the 32-bit history {hist[23:0], byte}.
REQ-021 done_o SHALL set when history == "DONE" (0x444F4E45).
REQ-022 err_o SHALL set when history[23:0] == "ERR" (0x455252).
REQ-023 done_o and err_o SHALL both remain set until reset.
REQ-024 Fetch latency SHALL be: request in cycle N, mem_stb_o in N+1, imem_ack_o in the same cycle as mem_ack_i.

Reset
REQ-025 On rst_in=0 the block SHALL immediately clear the FSM to IDLE, the history to 0, con_valid_o, done_o and err_o to 0, and all ack and mem control outputs to 0.
REQ-026 A reset in the middle of a transaction SHALL drop that transaction with no ack after release.

Structure
REQ-027 The FSM state enum and the DONE/ERR constants SHALL live in the shared package fazyrv_pkg.
REQ-028 The console history and flag logic SHALL be the sub-module fazyrv_con_sink.

Verification
REQ-029 Fetch-only: fetch 0x100 with mem ack after 2 cycles -> imem_ack_o once, 0 dmem_ack_o, mem_adr_o=0x40.
REQ-030 Simultaneous requests (fetch 0x0, load 0x200): imem granted then dmem in alternation; 2nd pair -> dmem first.
REQ-031 Console string: write bytes 'D','O','N','E' to 0x10000000 -> 4 con_valid_o pulses, done_o=1 after the 4th, mem_stb_o never set.
REQ-032 Error: write "xERR" -> err_o=1 and done_o=0; a console read -> dmem_dat_o=0 with an ack.
REQ-033 Abort: drop dmem_cyc_i in DMEM before ack -> no dmem_ack_o, FSM in IDLE, next fetch served.
REQ-034 Reset mid-DMEM: rst_in low for 1 cycle -> all outputs 0 immediately, no stray ack after release.
